// File: rtl/sm_remote_pkg.sv
// Shared definitions for the schoolMIPS remote debug command receiver.
// Holds the command opcodes, the reset probe address and the UART receiver
// state encodings. Optional feature macro: SM_REMOTE_PARITY_EN (adds StParity).
package sm_remote_pkg;

    // Command byte: [7:5] opcode, [4:0] argument. Opcodes 1xx are ignored.
    localparam logic [2:0] OP_SETADDR = 3'b000;
    localparam logic [2:0] OP_STEP    = 3'b001;
    localparam logic [2:0] OP_RUN     = 3'b010;
    localparam logic [2:0] OP_HALT    = 3'b011;

    // Register-file probe address after reset (v0).
    localparam logic [4:0] RESET_ADDR = 5'd2;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StStop     = 3'd3,
`ifdef SM_REMOTE_PARITY_EN
        StParity   = 3'd5,
`endif
        StWaitHigh = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sm_uart_rx.sv
// UART byte receiver: 2-flop input synchronizer, baud counter and frame FSM.
// Frame is 8N1, LSB first; with SM_REMOTE_PARITY_EN defined it is 8E1.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   rx         - serial line, idle high, asynchronous to clk
//   byte_valid - one-cycle pulse the cycle after a good stop-bit sample
//   byte_data  - received byte, stable while byte_valid is high
//   frame_err  - one-cycle pulse on bad stop bit (or bad parity)
module sm_uart_rx
    import sm_remote_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned CntW = $clog2(BAUD_DIV);
    localparam logic [CntW-1:0] HalfLoad = CntW'(BAUD_DIV / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(BAUD_DIV - 1);

    logic            rx_meta_q, rx_sync_q;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            expired;
`ifdef SM_REMOTE_PARITY_EN
    logic            par_err_q, par_err_d;
`endif

    assign expired    = (cnt_q == '0);
    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;

    // Only rx_sync_q is used downstream; raw rx never reaches other logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef SM_REMOTE_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            StIdle: begin
                if (!rx_sync_q) begin
                    // Half a bit to land the samples mid-bit.
                    cnt_d   = HalfLoad;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (expired) begin
                    if (!rx_sync_q) begin
                        cnt_d     = FullLoad;
                        bit_cnt_d = '0;
                        state_d   = StData;
                    end else begin
                        // Line went back high: a glitch, not a start bit.
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StData: begin
                if (expired) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = FullLoad;
                    if (bit_cnt_q == 3'd7) begin
`ifdef SM_REMOTE_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
`ifdef SM_REMOTE_PARITY_EN
            StParity: begin
                if (expired) begin
                    // Even parity: data bits plus parity bit XOR to zero.
                    par_err_d = rx_sync_q ^ (^shift_q);
                    cnt_d     = FullLoad;
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
`endif
            StStop: begin
                if (expired) begin
                    if (rx_sync_q) begin
                        state_d = StIdle;
`ifdef SM_REMOTE_PARITY_EN
                        if (par_err_q) begin
                            ferr_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                        end
`else
                        valid_d = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StWaitHigh: begin
                // Hold off through a break until the line idles high again.
                if (rx_sync_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef SM_REMOTE_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef SM_REMOTE_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

endmodule

// File: rtl/sm_remote_ctrl.sv
// Remote debug command receiver for the schoolMIPS board top. Receives
// single-byte commands over UART and drives the register probe address and
// the core clock-enable request. Optional macro: SM_REMOTE_PARITY_EN (8E1).
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   rx         - UART receive line, idle high
//   reg_addr   - register-file probe address
//   clk_enable - core clock enable request (run | busy)
//   cmd_valid  - one-cycle pulse when a command executes
//   frame_err  - one-cycle pulse on a malformed frame
//   busy       - high while a step burst is counting
module sm_remote_ctrl
    import sm_remote_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434,
    parameter int unsigned STEP_LEN = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [4:0] reg_addr,
    output logic       clk_enable,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       busy
);

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [2:0]  opcode;
    logic [4:0]  arg;
    logic [31:0] step_load;

    logic [4:0]  addr_q, addr_d;
    logic        run_q, run_d;
    logic [31:0] step_cnt_q, step_cnt_d;
    logic        busy_q, busy_d;
    logic        ce_q, ce_d;
    logic        cv_q, cv_d;

    sm_uart_rx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    assign opcode    = byte_data[7:5];
    assign arg       = byte_data[4:0];
    assign step_load = (32'(arg) + 32'd1) * 32'(STEP_LEN);

    always_comb begin
        addr_d     = addr_q;
        run_d      = run_q;
        cv_d       = 1'b0;
        step_cnt_d = (step_cnt_q != '0) ? step_cnt_q - 32'd1 : step_cnt_q;
        if (byte_valid) begin
            case (opcode)
                OP_SETADDR: begin
                    addr_d = arg;
                    cv_d   = 1'b1;
                end
                OP_STEP: begin
                    // A new STEP replaces any remaining count.
                    step_cnt_d = step_load;
                    cv_d       = 1'b1;
                end
                OP_RUN: begin
                    run_d = 1'b1;
                    cv_d  = 1'b1;
                end
                OP_HALT: begin
                    run_d      = 1'b0;
                    step_cnt_d = '0;
                    cv_d       = 1'b1;
                end
                default: ;
            endcase
        end
        // Registered from next-state so clk_enable is high exactly step_load cycles.
        busy_d = (step_cnt_d != '0);
        ce_d   = run_d | busy_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= RESET_ADDR;
            run_q      <= 1'b0;
            step_cnt_q <= '0;
            busy_q     <= 1'b0;
            ce_q       <= 1'b0;
            cv_q       <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            run_q      <= run_d;
            step_cnt_q <= step_cnt_d;
            busy_q     <= busy_d;
            ce_q       <= ce_d;
            cv_q       <= cv_d;
        end
    end

    assign reg_addr   = addr_q;
    assign clk_enable = ce_q;
    assign cmd_valid  = cv_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sm_remote_ctrl.sv
// Self-checking bench for sm_remote_ctrl with BAUD_DIV=8, STEP_LEN=4.
// The stimulus process also advances a command-level model; a single compare
// process checks every output on each falling clock edge and owns the counters.
module tb_sm_remote_ctrl;

    localparam int unsigned BD = 8;
    localparam int unsigned SL = 4;
`ifdef SM_REMOTE_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk;
    logic       rst;
    logic       rx;
    logic [4:0] reg_addr;
    logic       clk_enable;
    logic       cmd_valid;
    logic       frame_err;
    logic       busy;

    sm_remote_ctrl #(
        .BAUD_DIV(BD),
        .STEP_LEN(SL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .reg_addr  (reg_addr),
        .clk_enable(clk_enable),
        .cmd_valid (cmd_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Command-level model (written only by the stimulus process).
    logic [4:0] m_addr;
    bit         m_run, m_cv, m_fe;
    int         m_steps;
    int         cyc;
    bit         ev_valid, ev_fe;
    int         ev_cyc;
    logic [7:0] ev_byte;

    // Hand-computed literal pins (written by stimulus, checked by compare).
    bit         lit_addr_en, lit_len_en;
    logic [4:0] lit_addr;
    int         lit_len;

    // Counters (written only by the compare process).
    int n_cmp, n_bad, ce_run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    initial begin : compare
        n_cmp  = 0;
        n_bad  = 0;
        ce_run = 0;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                #1;
                ce_run = 0;
                check("rst_reg_addr", 32'(reg_addr), 32'd2);
                check("rst_clk_enable", 32'(clk_enable), 32'd0);
                check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
                check("rst_frame_err", 32'(frame_err), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
            end else begin
                check("reg_addr", 32'(reg_addr), 32'(m_addr));
                check("clk_enable", 32'(clk_enable), 32'(m_run || (m_steps > 0)));
                check("busy", 32'(busy), 32'(m_steps > 0));
                check("cmd_valid", 32'(cmd_valid), 32'(m_cv));
                check("frame_err", 32'(frame_err), 32'(m_fe));
                if (lit_addr_en) check("addr_pin", 32'(reg_addr), 32'(lit_addr));
                if (clk_enable === 1'b1) begin
                    ce_run++;
                end else begin
                    if (ce_run > 0 && lit_len_en) check("burst_len", 32'(ce_run), 32'(lit_len));
                    ce_run = 0;
                end
            end
        end
    end

    task automatic apply_cmd(input logic [7:0] b);
        case (b[7:5])
            3'd0: begin m_addr = b[4:0]; m_cv = 1'b1; end
            3'd1: begin m_steps = (int'(b[4:0]) + 1) * SL; m_cv = 1'b1; end
            3'd2: begin m_run = 1'b1; m_cv = 1'b1; end
            3'd3: begin m_run = 1'b0; m_steps = 0; m_cv = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (m_steps > 0) m_steps--;
        m_cv = 1'b0;
        m_fe = 1'b0;
        if (ev_valid && cyc == ev_cyc) begin
            ev_valid = 1'b0;
            if (ev_fe) m_fe = 1'b1;
            else apply_cmd(ev_byte);
        end
        #1;
    endtask

    task automatic model_reset();
        m_addr   = 5'd2;
        m_run    = 1'b0;
        m_steps  = 0;
        m_cv     = 1'b0;
        m_fe     = 1'b0;
        ev_valid = 1'b0;
    endtask

    // Start bit begins now; the command executes on the edge 8*NBITS later,
    // a frame error pulses one edge earlier (right after the stop sample).
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
        logic [10:0] bits;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = b;
`ifdef SM_REMOTE_PARITY_EN
        bits[9]   = (^b) ^ par_flip;
        bits[10]  = stop;
`else
        bits[9]   = stop;
`endif
        ev_valid = 1'b1;
        ev_byte  = b;
        ev_fe    = !stop || par_flip;
        ev_cyc   = ev_fe ? cyc + 8 * NBITS - 1 : cyc + 8 * NBITS;
        for (int i = 0; i < NBITS; i++) begin
            rx = bits[i];
            repeat (BD) tick();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin : stim
        rst         = 1'b1;
        rx          = 1'b1;
        cyc         = 0;
        lit_addr_en = 1'b0;
        lit_len_en  = 1'b0;
        lit_addr    = 5'd0;
        lit_len     = 0;
        model_reset();
        idle(4);
        rst = 1'b0;
        idle(6);

        // SETADDR 5: address 2 before, 5 right after the execute edge.
        lit_addr = 5'd2; lit_addr_en = 1'b1;
        send_frame(8'h05, 1'b1, 1'b0);
        lit_addr = 5'd5;
        idle(10);
        lit_addr_en = 1'b0;

        // STEP arg 2: 12 cycles of clk_enable.
        lit_len = 12; lit_len_en = 1'b1;
        send_frame(8'h22, 1'b1, 1'b0);
        idle(20);
        // STEP 31 then STEP 1 mid-burst: 80 cycles + reload of 8.
        lit_len = 88;
        send_frame(8'h3F, 1'b1, 1'b0);
        send_frame(8'h21, 1'b1, 1'b0);
        idle(20);
        // HALT mid-step: enable drops on HALT execute, 80 cycles after STEP.
        lit_len = 80;
        send_frame(8'h3F, 1'b1, 1'b0);
        send_frame(8'h60, 1'b1, 1'b0);
        idle(5);
        // RUN then HALT.
        send_frame(8'h40, 1'b1, 1'b0);
        send_frame(8'h60, 1'b1, 1'b0);
        idle(5);
        lit_len_en = 1'b0;

        // RUN while a step burst counts; enable stays high past the burst.
        send_frame(8'h3F, 1'b1, 1'b0);
        send_frame(8'h40, 1'b1, 1'b0);
        idle(100);
        send_frame(8'h60, 1'b1, 1'b0);
        idle(5);

        // Bad stop bit with line left low: one error, no command, no re-arm.
        send_frame(8'h07, 1'b0, 1'b0);
        idle(40);
        rx = 1'b1;
        idle(16);
        send_frame(8'h07, 1'b1, 1'b0);
        lit_addr = 5'd7; lit_addr_en = 1'b1;
        idle(5);
        lit_addr_en = 1'b0;

        // 3-cycle glitch: nothing happens.
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(20);

        // Back-to-back SETADDR 5 and ignored 0xE3.
        send_frame(8'h05, 1'b1, 1'b0);
        send_frame(8'hE3, 1'b1, 1'b0);
        lit_addr = 5'd5; lit_addr_en = 1'b1;
        idle(10);
        lit_addr_en = 1'b0;

        // Reset in the middle of a frame during a step burst.
        send_frame(8'h3F, 1'b1, 1'b0);
        rx = 1'b0;
        idle(BD);
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 0) ? 1'b1 : 1'b0;
            idle(BD);
        end
        rst = 1'b1;
        rx  = 1'b1;
        model_reset();
        idle(3);
        rst = 1'b0;
        idle(20);

`ifdef SM_REMOTE_PARITY_EN
        lit_addr = 5'd2; lit_addr_en = 1'b1;
        send_frame(8'h05, 1'b1, 1'b1);
        idle(10);
        send_frame(8'h05, 1'b1, 1'b0);
        lit_addr = 5'd5;
        idle(10);
        lit_addr_en = 1'b0;
`else
        lit_addr = 5'd2; lit_addr_en = 1'b1;
        send_frame(8'h09, 1'b1, 1'b0);
        lit_addr = 5'd9;
        idle(10);
        lit_addr_en = 1'b0;
`endif

        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
